// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_ctrl_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_e;

    typedef enum logic [3:0] {
        C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_LUI,
        C_AUIPC, C_JAL, C_JALR, C_FENCE, C_ILLEGAL
    } instr_class_e;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_RFN   = 3'd2;
    localparam logic [2:0] ALU_IFN   = 3'd3;
    localparam logic [2:0] ALU_PASSB = 3'd4;

    localparam logic [1:0] SRCA_RS1   = 2'd0;
    localparam logic [1:0] SRCA_PC    = 2'd1;
    localparam logic [1:0] SRCA_OLDPC = 2'd2;

    localparam logic [1:0] SRCB_RS2  = 2'd0;
    localparam logic [1:0] SRCB_IMM  = 2'd1;
    localparam logic [1:0] SRCB_FOUR = 2'd2;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;

    localparam logic [1:0] WB_ALUOUT = 2'd0;
    localparam logic [1:0] WB_MDR    = 2'd1;
    localparam logic [1:0] WB_PC     = 2'd2;

endpackage

// File: rtl/riscv_mc_ctrl_if.sv
// Controller <-> datapath/memory bundle; master is the controller side.
// Latency: n/a (wiring only).
// Backpressure: mem_req held until mem_ready.
interface riscv_mc_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       opcode;
    logic             br_cond;
    logic             mem_ready;
    logic             mem_req;
    logic             mem_we;
    logic             addr_sel;
    logic             ir_write;
    logic             mdr_write;
    logic             pc_write;
    logic [1:0]       pc_src;
    logic             old_pc_write;
    logic [1:0]       alu_src_a;
    logic [1:0]       alu_src_b;
    logic [2:0]       alu_op;
    logic             reg_write;
    logic [1:0]       wb_sel;
    logic             illegal;
    logic             bus_err;
    logic             retire;
    logic [CNT_W-1:0] retired_cnt;

    modport master (
        input  opcode, br_cond, mem_ready,
        output mem_req, mem_we, addr_sel, ir_write, mdr_write, pc_write, pc_src,
               old_pc_write, alu_src_a, alu_src_b, alu_op, reg_write, wb_sel,
               illegal, bus_err, retire, retired_cnt
    );

    modport slave (
        output opcode, br_cond, mem_ready,
        input  mem_req, mem_we, addr_sel, ir_write, mdr_write, pc_write, pc_src,
               old_pc_write, alu_src_a, alu_src_b, alu_op, reg_write, wb_sel,
               illegal, bus_err, retire, retired_cnt
    );
endinterface

// File: rtl/riscv_ctrl_decode.sv
// Opcode -> instruction class; SYSTEM and unknown opcodes are illegal.
// Latency: combinational.
// Backpressure: none.
module riscv_ctrl_decode
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0]   opcode,
    output instr_class_e cls,
    output logic         legal
);
    always_comb begin
        cls = C_ILLEGAL;
        case (opcode)
            OPC_OP:     cls = C_R;
            OPC_OP_IMM: cls = C_I;
            OPC_LOAD:   cls = C_LOAD;
            OPC_STORE:  cls = C_STORE;
            OPC_BRANCH: cls = C_BRANCH;
            OPC_LUI:    cls = C_LUI;
            OPC_AUIPC:  cls = C_AUIPC;
            OPC_JAL:    cls = C_JAL;
            OPC_JALR:   cls = C_JALR;
            OPC_FENCE:  cls = C_FENCE;
            default:    cls = C_ILLEGAL;
        endcase
    end

    assign legal = (cls != C_ILLEGAL);
endmodule

// File: rtl/riscv_mc_ctrl.sv
// Multi-cycle RV32I control FSM; memory-wait timeout under RISCV_CTRL_TIMEOUT_EN.
// Latency: 2-5 cycles per instruction plus memory wait cycles.
// Backpressure: stalls in FETCH/MEM with mem_req held until mem_ready.
module riscv_mc_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    riscv_mc_ctrl_if.master   bus
);
    state_e           state;
    instr_class_e     cls;
    logic             legal;
    logic             timeout;
    logic             bus_err_flag;
    logic [CNT_W-1:0] cnt_q;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    riscv_ctrl_decode u_decode (
        .opcode (bus.opcode),
        .cls    (cls),
        .legal  (legal)
    );

`ifdef RISCV_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wait_cnt;
    logic          waiting;
    logic          bus_err_q;

    assign waiting = ((state == S_FETCH) || (state == S_MEM)) && !bus.mem_ready;
    assign timeout = waiting && (wait_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt  <= '0;
            bus_err_q <= 1'b0;
        end else begin
            wait_cnt <= waiting ? wait_cnt + 1'b1 : '0;
            if (timeout)
                bus_err_q <= 1'b1;
        end
    end
    assign bus_err_flag = bus_err_q;
`else
    assign timeout      = 1'b0;
    assign bus_err_flag = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt_q <= '0;
        end else begin
            if (bus.retire)
                cnt_q <= cnt_q + 1'b1;
            case (state)
                S_IDLE:   state <= S_FETCH;
                S_FETCH:  if (bus.mem_ready) state <= S_DECODE;
                          else if (timeout) state <= S_TRAP;
                S_DECODE: if (!legal) state <= S_TRAP;
                          else if (cls == C_FENCE) state <= S_FETCH;
                          else state <= S_EXEC;
                S_EXEC: begin
                    case (cls)
                        C_R, C_I, C_LUI, C_AUIPC: state <= S_WB;
                        C_LOAD, C_STORE:          state <= S_MEM;
                        default:                  state <= S_FETCH;
                    endcase
                end
                S_MEM:    if (bus.mem_ready) state <= (cls == C_LOAD) ? S_WB : S_FETCH;
                          else if (timeout) state <= S_TRAP;
                S_WB:     state <= S_FETCH;
                S_TRAP:   state <= S_TRAP;
                default:  state <= S_IDLE;
            endcase
        end
    end

    // Outputs decode straight from state so a reset drops mem_req without waiting for a clock.
    always_comb begin
        bus.mem_req      = 1'b0;
        bus.mem_we       = 1'b0;
        bus.addr_sel     = 1'b0;
        bus.ir_write     = 1'b0;
        bus.mdr_write    = 1'b0;
        bus.pc_write     = 1'b0;
        bus.pc_src       = PCSRC_ALU;
        bus.old_pc_write = 1'b0;
        bus.alu_src_a    = SRCA_RS1;
        bus.alu_src_b    = SRCB_RS2;
        bus.alu_op       = ALU_ADD;
        bus.reg_write    = 1'b0;
        bus.wb_sel       = WB_ALUOUT;
        bus.illegal      = 1'b0;
        bus.retire       = 1'b0;
        case (state)
            S_FETCH: begin
                bus.mem_req = 1'b1;
                if (bus.mem_ready) begin
                    bus.ir_write     = 1'b1;
                    bus.old_pc_write = 1'b1;
                    bus.pc_write     = 1'b1;
                    bus.alu_src_a    = SRCA_PC;
                    bus.alu_src_b    = SRCB_FOUR;
                end
            end
            S_DECODE: begin
                bus.alu_src_a = SRCA_OLDPC;
                bus.alu_src_b = SRCB_IMM;
                bus.retire    = (cls == C_FENCE);
            end
            S_EXEC: begin
                case (cls)
                    C_R: bus.alu_op = ALU_RFN;
                    C_I: begin
                        bus.alu_src_b = SRCB_IMM;
                        bus.alu_op    = ALU_IFN;
                    end
                    C_LOAD, C_STORE: bus.alu_src_b = SRCB_IMM;
                    C_BRANCH: begin
                        bus.alu_op   = ALU_SUB;
                        bus.pc_write = bus.br_cond;
                        bus.pc_src   = bus.br_cond ? PCSRC_ALUOUT : PCSRC_ALU;
                        bus.retire   = 1'b1;
                    end
                    C_LUI: begin
                        bus.alu_src_b = SRCB_IMM;
                        bus.alu_op    = ALU_PASSB;
                    end
                    C_AUIPC: begin
                        bus.alu_src_a = SRCA_OLDPC;
                        bus.alu_src_b = SRCB_IMM;
                    end
                    C_JAL: begin
                        bus.pc_write  = 1'b1;
                        bus.pc_src    = PCSRC_ALUOUT;
                        bus.reg_write = 1'b1;
                        bus.wb_sel    = WB_PC;
                        bus.retire    = 1'b1;
                    end
                    C_JALR: begin
                        bus.alu_src_b = SRCB_IMM;
                        bus.pc_write  = 1'b1;
                        bus.reg_write = 1'b1;
                        bus.wb_sel    = WB_PC;
                        bus.retire    = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                bus.mem_req  = 1'b1;
                bus.addr_sel = 1'b1;
                bus.mem_we   = (cls == C_STORE);
                if (bus.mem_ready) begin
                    bus.mdr_write = (cls == C_LOAD);
                    bus.retire    = (cls == C_STORE);
                end
            end
            S_WB: begin
                bus.reg_write = 1'b1;
                bus.wb_sel    = (cls == C_LOAD) ? WB_MDR : WB_ALUOUT;
                bus.retire    = 1'b1;
            end
            S_TRAP:  bus.illegal = !bus_err_flag;
            default: ;
        endcase
    end

    assign bus.bus_err     = bus_err_flag;
    assign bus.retired_cnt = cnt_q;
endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// Bench for riscv_mc_ctrl: per-instruction expected cycle scripts checked every cycle.
module tb_riscv_mc_ctrl;
    localparam int CNT_W = 32;
    localparam int TO    = 8;

    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_FENCE = 7'b0001111;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BAD   = 7'b1111111;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    riscv_mc_ctrl_if #(.CNT_W(CNT_W)) bus ();
    riscv_mc_ctrl #(.CNT_W(CNT_W), .TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic       mem_req, mem_we, addr_sel, ir_write, mdr_write, pc_write;
        logic [1:0] pc_src;
        logic       old_pc_write;
        logic [1:0] alu_src_a, alu_src_b;
        logic [2:0] alu_op;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic       illegal, bus_err, retire;
    } out_t;

    typedef struct {
        logic [6:0] op;
        logic       br;
        logic       rdy;
        out_t       exp;
    } cyc_t;

    cyc_t seq_q[$];
    out_t snap_q[$];
    int   checks = 0, errors = 0;
    int   model_cnt = 0, dut_len = 0, last_len = 0;

    function automatic out_t dut_out();
        out_t o;
        o.mem_req = bus.mem_req;     o.mem_we = bus.mem_we;       o.addr_sel = bus.addr_sel;
        o.ir_write = bus.ir_write;   o.mdr_write = bus.mdr_write; o.pc_write = bus.pc_write;
        o.pc_src = bus.pc_src;       o.old_pc_write = bus.old_pc_write;
        o.alu_src_a = bus.alu_src_a; o.alu_src_b = bus.alu_src_b; o.alu_op = bus.alu_op;
        o.reg_write = bus.reg_write; o.wb_sel = bus.wb_sel;       o.illegal = bus.illegal;
        o.bus_err = bus.bus_err;     o.retire = bus.retire;
        return o;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [6:0] op, input logic br, input logic rdy, input out_t e);
        cyc_t c;
        c.op = op; c.br = br; c.rdy = rdy; c.exp = e;
        seq_q.push_back(c);
    endtask

    task automatic add_fetch(input logic [6:0] op, input logic br, input int waits);
        out_t e;
        for (int i = 0; i < waits; i++) begin
            e = '0; e.mem_req = 1'b1;
            push(op, br, 1'b0, e);
        end
        e = '0; e.mem_req = 1'b1; e.ir_write = 1'b1; e.old_pc_write = 1'b1;
        e.pc_write = 1'b1; e.alu_src_a = 2'd1; e.alu_src_b = 2'd2;
        push(op, br, 1'b1, e);
    endtask

    // Expected cycle script for one instruction, written from the per-state rules.
    task automatic add_instr(input logic [6:0] op, input logic br, input int fw, input int mw,
                             input logic tie);
        out_t e;
        add_fetch(op, br, fw);
        e = '0; e.alu_src_a = 2'd2; e.alu_src_b = 2'd1; e.retire = (op == OP_FENCE);
        push(op, br, tie, e);
        if (op == OP_FENCE) return;
        e = '0;
        case (op)
            OP_R:          e.alu_op = 3'd2;
            OP_I:          begin e.alu_src_b = 2'd1; e.alu_op = 3'd3; end
            OP_LD, OP_ST:  e.alu_src_b = 2'd1;
            OP_BR:         begin e.alu_op = 3'd1; e.retire = 1'b1;
                                 if (br) begin e.pc_write = 1'b1; e.pc_src = 2'd1; end end
            OP_LUI:        begin e.alu_src_b = 2'd1; e.alu_op = 3'd4; end
            OP_AUIPC:      begin e.alu_src_a = 2'd2; e.alu_src_b = 2'd1; end
            OP_JAL:        begin e.pc_write = 1'b1; e.pc_src = 2'd1; e.reg_write = 1'b1;
                                 e.wb_sel = 2'd2; e.retire = 1'b1; end
            OP_JALR:       begin e.alu_src_b = 2'd1; e.pc_write = 1'b1; e.reg_write = 1'b1;
                                 e.wb_sel = 2'd2; e.retire = 1'b1; end
            default: ;
        endcase
        push(op, br, tie, e);
        if (op == OP_LD || op == OP_ST) begin
            e = '0; e.mem_req = 1'b1; e.addr_sel = 1'b1; e.mem_we = (op == OP_ST);
            for (int i = 0; i < mw; i++) push(op, br, 1'b0, e);
            e.mdr_write = (op == OP_LD); e.retire = (op == OP_ST);
            push(op, br, 1'b1, e);
        end
        if (op == OP_R || op == OP_I || op == OP_LUI || op == OP_AUIPC || op == OP_LD) begin
            e = '0; e.reg_write = 1'b1; e.wb_sel = (op == OP_LD) ? 2'd1 : 2'd0; e.retire = 1'b1;
            push(op, br, tie, e);
        end
    endtask

    // Single compare point: drive one scripted cycle, check mid-cycle, advance.
    task automatic run_seq();
        out_t o;
        snap_q.delete();
        last_len = 0;
        for (int i = 0; i < seq_q.size(); i++) begin
            bus.opcode = seq_q[i].op; bus.br_cond = seq_q[i].br; bus.mem_ready = seq_q[i].rdy;
            @(negedge clk);
            o = dut_out();
            snap_q.push_back(o);
            check($sformatf("cyc%0d outputs", i), 64'(o), 64'(seq_q[i].exp));
            check($sformatf("cyc%0d retired_cnt", i), 64'(bus.retired_cnt), 64'(model_cnt));
            dut_len++;
            if (o.retire === 1'b1) begin last_len = dut_len; dut_len = 0; end
            if (seq_q[i].exp.retire) model_cnt++;
            @(posedge clk);
            #1;
        end
        seq_q.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("reset outputs", 64'(dut_out()), 64'd0);
        check("reset retired_cnt", 64'(bus.retired_cnt), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_cnt = 0;
        dut_len = 0;
    endtask

    initial begin
        out_t e;
        bus.opcode = '0; bus.br_cond = 1'b0; bus.mem_ready = 1'b0;
        #12;
        do_reset();

        push(OP_I, 1'b0, 1'b1, '0);
        add_instr(OP_I, 1'b0, 0, 0, 1'b1);
        run_seq();
        check("addi retired_cnt", 64'(bus.retired_cnt), 64'd1);
        check("addi cycles incl idle", 64'(last_len), 64'd5);
        check("addi reg_write cycle5", 64'(snap_q[4].reg_write), 64'd1);
        check("addi reg_write cycle4", 64'(snap_q[3].reg_write), 64'd0);

        add_instr(OP_LD, 1'b0, 2, 3, 1'b0);
        run_seq();
        check("lw cycles", 64'(last_len), 64'd10);
        check("lw mdr_write at mem ready", 64'(snap_q[8].mdr_write), 64'd1);
        check("lw mem_req in mem wait", 64'(snap_q[6].mem_req), 64'd1);

        add_instr(OP_BR, 1'b1, 0, 0, 1'b0);
        run_seq();
        check("beq taken cycles", 64'(last_len), 64'd3);
        check("beq taken pc_write/pc_src", 64'({snap_q[2].pc_write, snap_q[2].pc_src}), 64'b101);
        add_instr(OP_BR, 1'b0, 0, 0, 1'b0);
        run_seq();
        check("beq not-taken cycles", 64'(last_len), 64'd3);
        check("beq not-taken pc_write", 64'(snap_q[2].pc_write), 64'd0);

        add_instr(OP_LUI, 1'b0, 0, 0, 1'b0);
        run_seq();
        check("lui alu_op", 64'(snap_q[2].alu_op), 64'd4);
        check("lui alu_src_b", 64'(snap_q[2].alu_src_b), 64'd1);
        add_instr(OP_JALR, 1'b0, 0, 0, 1'b0);
        run_seq();
        check("jalr pc_write/reg_write/wb_sel",
              64'({snap_q[2].pc_write, snap_q[2].reg_write, snap_q[2].wb_sel}), 64'b1110);
        check("jalr cycles", 64'(last_len), 64'd3);

        add_instr(OP_FENCE, 1'b0, 0, 0, 1'b0);
        run_seq();
        check("fence cycles", 64'(last_len), 64'd2);
        add_instr(OP_ST, 1'b0, 1, 1, 1'b0);
        add_instr(OP_R, 1'b0, 0, 0, 1'b0);
        add_instr(OP_AUIPC, 1'b0, 0, 0, 1'b0);
        add_instr(OP_JAL, 1'b1, 0, 0, 1'b0);
        run_seq();
        check("retired_cnt after mix", 64'(bus.retired_cnt), 64'd11);

        // Park in a FETCH wait so the following reset abandons a live request.
        e = '0; e.mem_req = 1'b1;
        push(OP_ST, 1'b0, 1'b0, e);
        run_seq();
        do_reset();

        push(OP_BAD, 1'b0, 1'b0, '0);
        add_fetch(OP_BAD, 1'b0, 0);
        e = '0; e.alu_src_a = 2'd2; e.alu_src_b = 2'd1;
        push(OP_BAD, 1'b0, 1'b0, e);
        e = '0; e.illegal = 1'b1;
        for (int i = 0; i < 20; i++) push(OP_BAD, 1'b0, (i % 2) == 1, e);
        run_seq();
        check("trap illegal held", 64'(bus.illegal), 64'd1);
        do_reset();

        push(OP_I, 1'b0, 1'b0, '0);
`ifdef RISCV_CTRL_TIMEOUT_EN
        e = '0; e.mem_req = 1'b1;
        for (int i = 0; i < TO; i++) push(OP_I, 1'b0, 1'b0, e);
        e = '0; e.bus_err = 1'b1;
        for (int i = 0; i < 5; i++) push(OP_I, 1'b0, 1'b0, e);
`else
        e = '0; e.mem_req = 1'b1;
        for (int i = 0; i < 20; i++) push(OP_I, 1'b0, 1'b0, e);
`endif
        run_seq();
        do_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
